fpu_add_align_unit: RTL and testbench
=====================================

Name: fpu_add_align_unit

Overview:
- Pre-add alignment stage for the FP32 adder datapath; the counterpart to the multiplier's post-normalization, which shifts left to the leading one. This block shifts right to equalize exponents.
- Accepts two IEEE-754 single-precision operands and unpacks them.
- Orders the operands by magnitude and right-shifts the smaller mantissa by the exponent difference, producing guard/round/sticky bits.
- 2-stage pipeline with valid/ready handshake on both sides; feeds the add/sub + LOPD + normalize stages.

Parameters:
- SIZE_DATA, 32, operand width.
- SIZE_EXP, 8, exponent width.
- SIZE_MAN, 24, mantissa width including hidden bit.
- SIZE_EXT, 27, aligned small-mantissa width (SIZE_MAN + guard + round + sticky).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream operand pair valid.
- o_ready  output  1  block can accept a pair this cycle.
- i_operand_a  input  SIZE_DATA  operand A.
- i_operand_b  input  SIZE_DATA  operand B.
- i_sub  input  1  1 = A−B, 0 = A+B.
- o_valid  output  1  aligned result valid.
- i_ready  input  1  downstream accepts result.
- o_exponent  output  SIZE_EXP  larger operand's effective exponent.
- o_sign_big  output  1  sign of larger-magnitude operand (B sign already flipped when i_sub).
- o_eff_sub  output  1  effective subtraction (big and small signs differ).
- o_swap  output  1  1 when B had larger magnitude.
- o_mant_big  output  SIZE_MAN  larger mantissa with hidden bit.
- o_mant_small  output  SIZE_EXT  aligned smaller mantissa {24 bits, G, R, S}.
- o_special  output  1  either operand Inf/NaN (exponent all ones).

Behaviour:
- Reset (async assert, sync release): both stage-valid flags = 0, o_valid = 0, all data outputs = 0. o_ready = 1 while reset is deasserted and stage 1 is empty.
- Transfer rules:
  - Input handshake fires when i_valid && o_ready.
  - Output handshake fires when o_valid && i_ready.
  - Latency is exactly 2 cycles from accept to o_valid with no backpressure.
  - Throughput is 1 pair/cycle.
- Unpack:
  - exp == 0: hidden bit = 0, effective exponent = 1 (subnormal).
  - Otherwise: hidden bit = 1, effective exponent = the exponent field.
  - B sign is inverted when i_sub = 1.
- Stage 1 (registered on accept):
  - Compare {eff_exp, mant} of A vs B; B strictly larger → swap = 1. Equal magnitude → swap = 0.
  - diff = big_exp − small_exp, 8-bit, unsigned.
  - Register big/small fields, diff, swap, eff_sub, special.
- Stage 2 (registered when stage 1 advances):
  - ext = {small_mant, 3'b000}.
  - If diff ≥ SIZE_EXT: shifted = 0, sticky = |ext.
  - Otherwise: shifted = ext >> diff, sticky = OR of the bits shifted out.
  - o_mant_small = {shifted[26:1], shifted[0] | sticky}.
- Pipeline control:
  - s2_adv = !s2_valid || i_ready.
  - s1_adv = s1_valid && s2_adv.
  - o_ready = !s1_valid || s2_adv.
  - Stage 2 holds its data stable while o_valid && !i_ready.
  - Stage 1 holds its data while it cannot advance.
  - Simultaneous input accept, stage advance and output accept in one cycle are legal; no bubble is inserted.
- Ordering: strict in-order, no drops, no duplicates.
- o_special: the block does not interpret NaN/Inf; data is still computed and flag = 1. Zero operands need no special case (mant 0, exp eff 1).
- Reset mid-operation: in-flight pairs are discarded, o_valid = 0 next edge, nothing is replayed after release.

Test Plan:
- A=0x3F800000, B=0x3E800000, i_sub=0 → after 2 cycles:
  - o_exponent=0x7F, o_swap=0, o_mant_big=0x800000, o_mant_small=0x1000000, o_eff_sub=0.
- A=0x4B800000, B=0x3F800001 (diff 24) → o_exponent=0x97, o_mant_small=0x0000005 (bit3 shifted out → sticky).
- A=0x3F800000, B=0x4F800000, i_sub=1 → o_swap=1, o_exponent=0x9F, o_sign_big=1, o_eff_sub=1, o_mant_small=0x0000001 (diff 32 ≥ 27, sticky only).
- A=B=0x00000001 (subnormal), i_sub=1 → o_exponent=0x01, o_swap=0, o_mant_big=0x000001, o_mant_small=0x0000008, o_eff_sub=1.
- Backpressure: 4 back-to-back pairs with i_ready=0 for cycles 2–4 →
  - o_ready=0 while both stages are full.
  - All 4 results emerge in order, no loss or duplicate.
  - Held outputs stay stable while stalled.
- Pulse i_rst_n low while 2 pairs are in flight → o_valid=0 and outputs=0 immediately; after release o_ready=1 and no stale result appears.

Source files
------------

// File: rtl/fpu_add_align_unit.sv
// ---------------------------------------------------------------------------
// fpu_add_align_unit
//
// Pre-add alignment stage of the FP32 adder datapath. Unpacks two IEEE-754
// single-precision operands, orders them by magnitude and right-shifts the
// smaller mantissa by the exponent difference, producing guard/round/sticky
// bits for the downstream add/sub, LOPD and normalize stages.
// Two-stage pipeline with a valid/ready handshake on both sides.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready  upstream handshake for an operand pair
//   i_operand_a/b    FP32 operands
//   i_sub            1 = A-B, 0 = A+B
//   o_valid/i_ready  downstream handshake for the aligned result
//   o_exponent       larger operand's effective exponent
//   o_sign_big       sign of the larger-magnitude operand (B sign flipped on sub)
//   o_eff_sub        big and small signs differ
//   o_swap           B had the larger magnitude
//   o_mant_big       larger mantissa including hidden bit
//   o_mant_small     aligned smaller mantissa {24 bits, G, R, S}
//   o_special        either operand has an all-ones exponent (Inf/NaN)
// ---------------------------------------------------------------------------
module fpu_add_align_unit #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_MAN  = 24,
  parameter int SIZE_EXT  = 27
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_operand_a,
  input  logic [SIZE_DATA-1:0] i_operand_b,
  input  logic                 i_sub,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_EXP-1:0]  o_exponent,
  output logic                 o_sign_big,
  output logic                 o_eff_sub,
  output logic                 o_swap,
  output logic [SIZE_MAN-1:0]  o_mant_big,
  output logic [SIZE_EXT-1:0]  o_mant_small,
  output logic                 o_special
);

  localparam int SIZE_FRAC = SIZE_MAN - 1;
  localparam int SIZE_GRS  = SIZE_EXT - SIZE_MAN;
  localparam int SIZE_MAG  = SIZE_EXP + SIZE_MAN;
  localparam logic [SIZE_EXP-1:0] EXT_LIMIT = SIZE_EXP'(SIZE_EXT);
  localparam logic [SIZE_EXP-1:0] EXP_ONE   = SIZE_EXP'(1);

  // Subnormals and zero use an effective exponent of 1 with hidden bit 0.
  function automatic logic [SIZE_EXP-1:0] eff_exp(input logic [SIZE_EXP-1:0] e);
    return (e == '0) ? EXP_ONE : e;
  endfunction

  // Right-shift {m, GRS=000} by d; every bit pushed past the LSB is folded
  // into the sticky position so rounding downstream stays exact.
  function automatic logic [SIZE_EXT-1:0] align_shift(
    input logic [SIZE_MAN-1:0] m,
    input logic [SIZE_EXP-1:0] d
  );
    logic [SIZE_EXT-1:0] ext;
    logic [SIZE_EXT-1:0] shifted;
    logic [SIZE_EXT-1:0] lost_mask;
    logic                sticky;
    ext       = {m, {SIZE_GRS{1'b0}}};
    lost_mask = '0;
    if (d >= EXT_LIMIT) begin
      shifted = '0;
      sticky  = |ext;
    end else begin
      shifted   = ext >> d;
      lost_mask = ~({SIZE_EXT{1'b1}} << d);
      sticky    = |(ext & lost_mask);
    end
    return {shifted[SIZE_EXT-1:1], shifted[0] | sticky};
  endfunction

  // Unpack
  logic                sign_a, sign_b;
  logic [SIZE_EXP-1:0] exp_a, exp_b, eexp_a, eexp_b;
  logic [SIZE_MAN-1:0] mant_a, mant_b;
  logic [SIZE_MAG-1:0] mag_a, mag_b;

  always_comb begin
    sign_a = i_operand_a[SIZE_DATA-1];
    sign_b = i_operand_b[SIZE_DATA-1] ^ i_sub;
    exp_a  = i_operand_a[SIZE_DATA-2 -: SIZE_EXP];
    exp_b  = i_operand_b[SIZE_DATA-2 -: SIZE_EXP];
    eexp_a = eff_exp(exp_a);
    eexp_b = eff_exp(exp_b);
    mant_a = {(exp_a != '0), i_operand_a[SIZE_FRAC-1:0]};
    mant_b = {(exp_b != '0), i_operand_b[SIZE_FRAC-1:0]};
    mag_a  = {eexp_a, mant_a};
    mag_b  = {eexp_b, mant_b};
  end

  // Order by magnitude; ties keep A as the big operand.
  logic                swap_d;
  logic [SIZE_EXP-1:0] exp_big_d, exp_small_d, diff_d;
  logic [SIZE_MAN-1:0] mant_big_d, mant_small_d;
  logic                sign_big_d, eff_sub_d, special_d;

  always_comb begin
    swap_d       = (mag_b > mag_a);
    exp_big_d    = swap_d ? eexp_b : eexp_a;
    exp_small_d  = swap_d ? eexp_a : eexp_b;
    mant_big_d   = swap_d ? mant_b : mant_a;
    mant_small_d = swap_d ? mant_a : mant_b;
    sign_big_d   = swap_d ? sign_b : sign_a;
    eff_sub_d    = sign_a ^ sign_b;
    special_d    = (&exp_a) | (&exp_b);
    diff_d       = exp_big_d - exp_small_d;
  end

  // Pipeline control
  logic vld_p1_q, vld_p2_q;
  logic s2_adv, s1_adv, accept;

  always_comb begin
    s2_adv  = !vld_p2_q || i_ready;
    s1_adv  = vld_p1_q && s2_adv;
    o_ready = i_rst_n && (!vld_p1_q || s2_adv);
    accept  = i_valid && o_ready;
  end

  // ---- stage 1: unpacked, ordered operands ----
  logic                swap_p1_q, sign_big_p1_q, eff_sub_p1_q, special_p1_q;
  logic [SIZE_EXP-1:0] exp_big_p1_q, diff_p1_q;
  logic [SIZE_MAN-1:0] mant_big_p1_q, mant_small_p1_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1_q        <= 1'b0;
      swap_p1_q       <= 1'b0;
      sign_big_p1_q   <= 1'b0;
      eff_sub_p1_q    <= 1'b0;
      special_p1_q    <= 1'b0;
      exp_big_p1_q    <= '0;
      diff_p1_q       <= '0;
      mant_big_p1_q   <= '0;
      mant_small_p1_q <= '0;
    end else begin
      if (accept) begin
        vld_p1_q        <= 1'b1;
        swap_p1_q       <= swap_d;
        sign_big_p1_q   <= sign_big_d;
        eff_sub_p1_q    <= eff_sub_d;
        special_p1_q    <= special_d;
        exp_big_p1_q    <= exp_big_d;
        diff_p1_q       <= diff_d;
        mant_big_p1_q   <= mant_big_d;
        mant_small_p1_q <= mant_small_d;
      end else if (s1_adv) begin
        vld_p1_q <= 1'b0;
      end
    end
  end

  // ---- stage 2: aligned small mantissa, drives the outputs ----
  logic                swap_p2_q, sign_big_p2_q, eff_sub_p2_q, special_p2_q;
  logic [SIZE_EXP-1:0] exp_p2_q;
  logic [SIZE_MAN-1:0] mant_big_p2_q;
  logic [SIZE_EXT-1:0] mant_small_p2_q;
  logic [SIZE_EXT-1:0] aligned_d;

  always_comb begin
    aligned_d = align_shift(mant_small_p1_q, diff_p1_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p2_q        <= 1'b0;
      swap_p2_q       <= 1'b0;
      sign_big_p2_q   <= 1'b0;
      eff_sub_p2_q    <= 1'b0;
      special_p2_q    <= 1'b0;
      exp_p2_q        <= '0;
      mant_big_p2_q   <= '0;
      mant_small_p2_q <= '0;
    end else if (s2_adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        swap_p2_q       <= swap_p1_q;
        sign_big_p2_q   <= sign_big_p1_q;
        eff_sub_p2_q    <= eff_sub_p1_q;
        special_p2_q    <= special_p1_q;
        exp_p2_q        <= exp_big_p1_q;
        mant_big_p2_q   <= mant_big_p1_q;
        mant_small_p2_q <= aligned_d;
      end
    end
  end

  assign o_valid      = vld_p2_q;
  assign o_exponent   = exp_p2_q;
  assign o_sign_big   = sign_big_p2_q;
  assign o_eff_sub    = eff_sub_p2_q;
  assign o_swap       = swap_p2_q;
  assign o_mant_big   = mant_big_p2_q;
  assign o_mant_small = mant_small_p2_q;
  assign o_special    = special_p2_q;

endmodule

// File: tb/tb_fpu_add_align_unit.sv
// ---------------------------------------------------------------------------
// tb_fpu_add_align_unit
//
// Directed-vector bench for fpu_add_align_unit: reset state, single-pair
// alignment cases, backpressure ordering/hold, and reset while in flight.
// ---------------------------------------------------------------------------
module tb_fpu_add_align_unit;

  logic        clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_exponent;
  logic        o_sign_big;
  logic        o_eff_sub;
  logic        o_swap;
  logic [23:0] o_mant_big;
  logic [26:0] o_mant_small;
  logic        o_special;

  int n_chk  = 0;
  int n_pass = 0;

  fpu_add_align_unit dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_operand_a  (i_operand_a),
    .i_operand_b  (i_operand_b),
    .i_sub        (i_sub),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_exponent   (o_exponent),
    .o_sign_big   (o_sign_big),
    .o_eff_sub    (o_eff_sub),
    .o_swap       (o_swap),
    .o_mant_big   (o_mant_big),
    .o_mant_small (o_mant_small),
    .o_special    (o_special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One isolated pair with i_ready=1; checks 2-cycle latency and all fields.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [7:0] e_exp, input logic e_sign,
                        input logic e_effsub, input logic e_swap, input logic [23:0] e_mb,
                        input logic [26:0] e_ms, input logic e_spec);
    @(negedge clk);
    i_operand_a = a;
    i_operand_b = b;
    i_sub       = sub;
    i_valid     = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(o_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"},      32'(o_valid),      32'd1);
    chk({tag, "_exponent"},   32'(o_exponent),   32'(e_exp));
    chk({tag, "_sign_big"},   32'(o_sign_big),   32'(e_sign));
    chk({tag, "_eff_sub"},    32'(o_eff_sub),    32'(e_effsub));
    chk({tag, "_swap"},       32'(o_swap),       32'(e_swap));
    chk({tag, "_mant_big"},   32'(o_mant_big),   32'(e_mb));
    chk({tag, "_mant_small"}, 32'(o_mant_small), 32'(e_ms));
    chk({tag, "_special"},    32'(o_special),    32'(e_spec));
  endtask

  // A = 1.0 against B = 0.5, 0.25, 0.125, 0.0625 (diff 1..4)
  logic [31:0] bp_b  [4] = '{32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000};
  logic [26:0] bp_ms [4] = '{27'h2000000, 27'h1000000, 27'h0800000, 27'h0400000};

  initial begin
    int idx;
    int sent;
    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_operand_a = '0;
    i_operand_b = '0;
    i_sub       = 1'b0;
    i_ready     = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_o_valid",    32'(o_valid),      32'd0);
    chk("rst_mant_small", 32'(o_mant_small), 32'd0);
    chk("rst_exponent",   32'(o_exponent),   32'd0);
    chk("rst_mant_big",   32'(o_mant_big),   32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("rst_rel_o_ready", 32'(o_ready), 32'd1);

    single("t1_add",  32'h3F800000, 32'h3E800000, 1'b0,
           8'h7F, 1'b0, 1'b0, 1'b0, 24'h800000, 27'h1000000, 1'b0);
    single("t2_d24",  32'h4B800000, 32'h3F800001, 1'b0,
           8'h97, 1'b0, 1'b0, 1'b0, 24'h800000, 27'h0000005, 1'b0);
    single("t3_swap", 32'h3F800000, 32'h4F800000, 1'b1,
           8'h9F, 1'b1, 1'b1, 1'b1, 24'h800000, 27'h0000001, 1'b0);
    single("t4_sub",  32'h00000001, 32'h00000001, 1'b1,
           8'h01, 1'b0, 1'b1, 1'b0, 24'h000001, 27'h0000008, 1'b0);
    single("t5_inf",  32'h7F800000, 32'h3F800000, 1'b0,
           8'hFF, 1'b0, 1'b0, 1'b0, 24'h800000, 27'h0000001, 1'b1);

    // Backpressure: 4 back-to-back pairs, i_ready low in cycles 2..4.
    i_operand_a = 32'h3F800000;
    i_sub       = 1'b0;
    idx  = 0;
    sent = 0;
    for (int c = 0; c < 30 && idx < 4; c++) begin
      @(negedge clk);
      i_ready = !(c >= 2 && c <= 4);
      if (sent < 4) begin
        i_valid     = 1'b1;
        i_operand_b = bp_b[sent];
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (!i_ready) begin
        chk("bp_o_ready_low", 32'(o_ready),      32'd0);
        chk("bp_hold_valid",  32'(o_valid),      32'd1);
        chk("bp_hold_data",   32'(o_mant_small), 32'(bp_ms[0]));
      end
      if (o_valid && i_ready) begin
        if (idx < 4) chk("bp_order", 32'(o_mant_small), 32'(bp_ms[idx]));
        idx++;
      end
      if (i_valid && o_ready) sent++;
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("bp_count", 32'(idx), 32'd4);
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_dup", 32'(o_valid), 32'd0);
    end

    // Reset while two pairs are in flight.
    @(negedge clk);
    i_valid     = 1'b1;
    i_operand_b = bp_b[0];
    @(negedge clk);
    i_operand_b = bp_b[1];
    @(negedge clk);
    i_valid = 1'b0;
    chk("rf_inflight_valid", 32'(o_valid), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("rf_o_valid",    32'(o_valid),      32'd0);
    chk("rf_mant_small", 32'(o_mant_small), 32'd0);
    chk("rf_mant_big",   32'(o_mant_big),   32'd0);
    chk("rf_exponent",   32'(o_exponent),   32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    chk("rf_rel_o_ready", 32'(o_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("rf_no_stale", 32'(o_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
